mod_hazard_ctrl: RTL and testbench

- Pipeline hazard controller that sequences the pipeline registers through their stall and flush controls: PC, mod_if2id, ID/EX and EX/MEM.
- Resolves these hazards:
  - Load-use
  - EX-stage redirect (branch/jump taken), with optional post-redirect fetch squash
  - Multi-cycle EX operations (mul/div), with a watchdog
  - Instruction-memory wait
- Also keeps a saturating stall-cycle performance counter.
- Control outputs are combinational from registered state plus current inputs; all internal state is registered.

---
 rtl/mod_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mod_hazard_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_hazard_ctrl.sv
// Pipeline hazard controller: sequences PC/IF-ID/ID-EX/EX-MEM stall and flush controls
// for load-use, EX redirects, multi-cycle EX ops (with watchdog) and imem wait.
module mod_hazard_ctrl #(
    parameter int unsigned SQUASH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT    = 64,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic             ex_mc_start_i,
    input  logic             mc_done_i,
    input  logic             imem_ready_i,
    output logic             pc_stall_o,
    output logic             if2id_stall_o,
    output logic             if2id_flush_o,
    output logic             id2ex_stall_o,
    output logic             id2ex_flush_o,
    output logic             ex2mem_flush_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned SQ_W = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;
    localparam int unsigned MC_W = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_WAIT = 2'd1,
        S_SQUASH  = 2'd2
    } state_t;

    state_t           r_state;
    logic [SQ_W-1:0]  r_sq_cnt;
    logic [MC_W-1:0]  r_mc_cnt;
    logic             r_mc_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state_nxt;
    logic [SQ_W-1:0]  w_sq_nxt;
    logic [MC_W-1:0]  w_mc_nxt;
    logic             w_to_set;
    logic             w_load_use;
    logic             w_pc_stall;
    logic             w_if2id_stall;
    logic             w_if2id_flush;
    logic             w_id2ex_stall;
    logic             w_id2ex_flush;
    logic             w_ex2mem_flush;

    assign w_load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                        ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                         (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Next-state and control decode; the redirect target loads into PC, so PC is never held then.
    always_comb begin
        w_state_nxt    = r_state;
        w_sq_nxt       = r_sq_cnt;
        w_mc_nxt       = r_mc_cnt;
        w_to_set       = 1'b0;
        w_pc_stall     = 1'b0;
        w_if2id_stall  = 1'b0;
        w_if2id_flush  = 1'b0;
        w_id2ex_stall  = 1'b0;
        w_id2ex_flush  = 1'b0;
        w_ex2mem_flush = 1'b0;
        case (r_state)
            S_RUN: begin
                if (ex_redirect_i) begin
                    w_if2id_flush = 1'b1;
                    w_id2ex_flush = 1'b1;
                    if (SQUASH_CYCLES > 0) begin
                        w_state_nxt = S_SQUASH;
                        w_sq_nxt    = SQ_W'(SQUASH_CYCLES);
                    end
                end else if (ex_mc_start_i && !mc_done_i) begin
                    w_pc_stall     = 1'b1;
                    w_if2id_stall  = 1'b1;
                    w_id2ex_stall  = 1'b1;
                    w_ex2mem_flush = 1'b1;
                    w_state_nxt    = S_MC_WAIT;
                    w_mc_nxt       = MC_W'(1);
                end else if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_if2id_stall = 1'b1;
                    w_id2ex_flush = 1'b1;
                end else if (!imem_ready_i) begin
                    w_pc_stall    = 1'b1;
                    w_if2id_flush = 1'b1;
                end
            end
            S_MC_WAIT: begin
                if (mc_done_i) begin
                    w_state_nxt = S_RUN;
                    w_mc_nxt    = '0;
                end else if (r_mc_cnt == MC_W'(MC_TIMEOUT)) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_RUN;
                    w_mc_nxt    = '0;
                end else begin
                    w_pc_stall     = 1'b1;
                    w_if2id_stall  = 1'b1;
                    w_id2ex_stall  = 1'b1;
                    w_ex2mem_flush = 1'b1;
                    w_mc_nxt       = r_mc_cnt + MC_W'(1);
                end
            end
            S_SQUASH: begin
                if (ex_redirect_i) begin
                    w_if2id_flush = 1'b1;
                    w_id2ex_flush = 1'b1;
                    w_sq_nxt      = SQ_W'(SQUASH_CYCLES);
                end else begin
                    w_if2id_flush = 1'b1;
                    w_pc_stall    = !imem_ready_i;
                    if (imem_ready_i) begin
                        if (r_sq_cnt == SQ_W'(1)) begin
                            w_state_nxt = S_RUN;
                            w_sq_nxt    = '0;
                        end else begin
                            w_sq_nxt = r_sq_cnt - SQ_W'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_sq_nxt    = '0;
                w_mc_nxt    = '0;
            end
        endcase
    end

    // Gate controls with reset so nothing leaks out while rst_ni is low.
    assign pc_stall_o     = w_pc_stall     & rst_ni;
    assign if2id_stall_o  = w_if2id_stall  & rst_ni;
    assign if2id_flush_o  = w_if2id_flush  & rst_ni;
    assign id2ex_stall_o  = w_id2ex_stall  & rst_ni;
    assign id2ex_flush_o  = w_id2ex_flush  & rst_ni;
    assign ex2mem_flush_o = w_ex2mem_flush & rst_ni;
    assign mc_timeout_o   = r_mc_timeout;
    assign stall_cnt_o    = r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_RUN;
            r_sq_cnt     <= '0;
            r_mc_cnt     <= '0;
            r_mc_timeout <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sq_cnt <= w_sq_nxt;
            r_mc_cnt <= w_mc_nxt;
            if (w_to_set) begin
                r_mc_timeout <= 1'b1;
            end
            if (w_pc_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mod_hazard_ctrl.sv
// Bench for mod_hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model, on two parameterisations (with and without squash).
module tb_mod_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       use1, use2, is_load, redir, mc_start, mc_done, imem_rdy;

    logic       a_pc, a_ifs, a_iff, a_ids, a_idf, a_exf, a_to;
    logic [7:0] a_cnt;
    logic       b_pc, b_ifs, b_iff, b_ids, b_idf, b_exf, b_to;
    logic [3:0] b_cnt;

    wire [5:0] ctl_a = {a_pc, a_ifs, a_iff, a_ids, a_idf, a_exf};
    wire [5:0] ctl_b = {b_pc, b_ifs, b_iff, b_ids, b_idf, b_exf};

    // {pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush, ex2mem_flush}
    localparam logic [5:0] C_IDLE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_MC   = 6'b110101;
    localparam logic [5:0] C_RED  = 6'b001010;
    localparam logic [5:0] C_SQ   = 6'b001000;
    localparam logic [5:0] C_IMW  = 6'b101000;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mod_hazard_ctrl #(.SQUASH_CYCLES(2), .MC_TIMEOUT(8), .CNT_W(8)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .ex_rd_i(ex_rd), .ex_is_load_i(is_load), .ex_redirect_i(redir),
        .ex_mc_start_i(mc_start), .mc_done_i(mc_done), .imem_ready_i(imem_rdy),
        .pc_stall_o(a_pc), .if2id_stall_o(a_ifs), .if2id_flush_o(a_iff),
        .id2ex_stall_o(a_ids), .id2ex_flush_o(a_idf), .ex2mem_flush_o(a_exf),
        .mc_timeout_o(a_to), .stall_cnt_o(a_cnt));

    mod_hazard_ctrl #(.SQUASH_CYCLES(0), .MC_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .ex_rd_i(ex_rd), .ex_is_load_i(is_load), .ex_redirect_i(redir),
        .ex_mc_start_i(mc_start), .mc_done_i(mc_done), .imem_ready_i(imem_rdy),
        .pc_stall_o(b_pc), .if2id_stall_o(b_ifs), .if2id_flush_o(b_iff),
        .id2ex_stall_o(b_ids), .id2ex_flush_o(b_idf), .ex2mem_flush_o(b_exf),
        .mc_timeout_o(b_to), .stall_cnt_o(b_cnt));

    // Reference model: squash cycles left, MC wait cycle index (0 = no op pending),
    // sticky watchdog flag and stall count, one slot per DUT instance.
    int P_SQ[2]  = '{2, 0};
    int P_MCT[2] = '{8, 4};
    int P_MAX[2] = '{255, 15};
    int m_sq[2], m_mc[2], m_cnt[2], n_sq[2], n_mc[2], n_cnt[2];
    bit m_to[2], n_to[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sq[k] = 0; m_mc[k] = 0; m_cnt[k] = 0; m_to[k] = 1'b0;
        end
    endtask

    task automatic model_eval(input int k, output logic [5:0] ctl);
        bit lu;
        lu = is_load && (ex_rd != 0) &&
             ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
        ctl = C_IDLE;
        n_sq[k] = m_sq[k]; n_mc[k] = m_mc[k]; n_to[k] = m_to[k];
        if (m_mc[k] > 0) begin
            if (mc_done) n_mc[k] = 0;
            else if (m_mc[k] == P_MCT[k]) begin n_mc[k] = 0; n_to[k] = 1'b1; end
            else begin ctl = C_MC; n_mc[k] = m_mc[k] + 1; end
        end else if (m_sq[k] > 0) begin
            if (redir) begin ctl = C_RED; n_sq[k] = P_SQ[k]; end
            else if (imem_rdy) begin ctl = C_SQ; n_sq[k] = m_sq[k] - 1; end
            else ctl = C_SQ | 6'b100000;
        end else if (redir) begin
            ctl = C_RED; n_sq[k] = P_SQ[k];
        end else if (mc_start && !mc_done) begin
            ctl = C_MC; n_mc[k] = 1;
        end else if (lu) ctl = C_LU;
        else if (!imem_rdy) ctl = C_IMW;
        n_cnt[k] = (ctl[5] && m_cnt[k] < P_MAX[k]) ? m_cnt[k] + 1 : m_cnt[k];
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            m_sq[k] = n_sq[k]; m_mc[k] = n_mc[k]; m_cnt[k] = n_cnt[k]; m_to[k] = n_to[k];
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic ld,
                          input logic rdr, input logic mcs, input logic mcd, input logic imr);
        id_rs1 = rs1; id_rs2 = rs2; use1 = u1; use2 = u2; ex_rd = rd; is_load = ld;
        redir = rdr; mc_start = mcs; mc_done = mcd; imem_rdy = imr;
    endtask

    task automatic set_idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Inputs change at posedge+1; outputs are sampled 4 ns later, halfway to the next edge.
    task automatic settle();
        #4;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        set_idle();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        set_in(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        settle();
        checks++; if (ctl_a !== C_IDLE || ctl_b !== C_IDLE) begin errors++;
            $display("FAIL reset_ctl got a=%b b=%b exp %b", ctl_a, ctl_b, C_IDLE); end
        checks++; if (a_cnt !== 8'd0 || b_cnt !== 4'd0 || a_to !== 1'b0 || b_to !== 1'b0) begin errors++;
            $display("FAIL reset_regs got cnt=%0d/%0d to=%b/%b exp 0", a_cnt, b_cnt, a_to, b_to); end
        cyc();
        apply_reset();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++; if (ctl_a !== C_LU || ctl_b !== C_LU) begin errors++;
            $display("FAIL lu_stall got a=%b b=%b exp %b", ctl_a, ctl_b, C_LU); end
        cyc();
        set_idle();
        settle();
        checks++; if (ctl_a !== C_IDLE) begin errors++;
            $display("FAIL lu_one_bubble got %b exp %b", ctl_a, C_IDLE); end
        checks++; if (a_cnt !== 8'd1) begin errors++;
            $display("FAIL lu_cnt got %0d exp 1", a_cnt); end
        cyc();
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++; if (ctl_a !== C_IDLE) begin errors++;
            $display("FAIL lu_rd0 got %b exp %b", ctl_a, C_IDLE); end
        cyc();
        set_in(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++; if (ctl_a !== C_IDLE) begin errors++;
            $display("FAIL lu_unused_rs1 got %b exp %b", ctl_a, C_IDLE); end
        cyc();
        set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++; if (ctl_a !== C_LU) begin errors++;
            $display("FAIL lu_rs1 got %b exp %b", ctl_a, C_LU); end
        cyc();
        set_idle();
        settle();
        checks++; if (a_cnt !== 8'd2) begin errors++;
            $display("FAIL lu_cnt2 got %0d exp 2", a_cnt); end
    endtask

    task automatic test_redirect();
        logic [5:0] exp_a[4] = '{C_RED, C_SQ, C_SQ, C_IDLE};
        logic [5:0] exp_b[4] = '{C_RED, C_IDLE, C_IDLE, C_IDLE};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            redir = (i == 0);
            settle();
            checks++; if (ctl_a !== exp_a[i] || ctl_b !== exp_b[i]) begin errors++;
                $display("FAIL redirect_c%0d got a=%b b=%b exp a=%b b=%b",
                         i, ctl_a, ctl_b, exp_a[i], exp_b[i]); end
            cyc();
        end
    endtask

    task automatic test_mc();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            mc_start = (i == 0);
            mc_done  = (i == 5);
            settle();
            checks++; if (ctl_a !== ((i < 5) ? C_MC : C_IDLE)) begin errors++;
                $display("FAIL mc_c%0d got %b exp %b", i, ctl_a, (i < 5) ? C_MC : C_IDLE); end
            cyc();
        end
        set_idle();
        settle();
        checks++; if (a_cnt !== 8'd5 || a_to !== 1'b0) begin errors++;
            $display("FAIL mc_cnt got cnt=%0d to=%b exp cnt=5 to=0", a_cnt, a_to); end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        checks++; if (ctl_a !== C_IDLE) begin errors++;
            $display("FAIL mc_single_cycle got %b exp %b", ctl_a, C_IDLE); end
        cyc();
    endtask

    task automatic test_watchdog();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            mc_start = (i == 0);
            settle();
            checks++; if (ctl_b !== ((i < 4) ? C_MC : C_IDLE) || b_to !== 1'b0) begin errors++;
                $display("FAIL wd_c%0d got ctl=%b to=%b exp ctl=%b to=0",
                         i, ctl_b, b_to, (i < 4) ? C_MC : C_IDLE, b_to); end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            set_idle();
            settle();
            checks++; if (b_to !== 1'b1 || ctl_b !== C_IDLE || b_cnt !== 4'd4) begin errors++;
                $display("FAIL wd_sticky%0d got to=%b ctl=%b cnt=%0d exp to=1 ctl=0 cnt=4",
                         i, b_to, ctl_b, b_cnt); end
            cyc();
        end
        set_in(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++; if (ctl_b !== C_LU) begin errors++;
            $display("FAIL wd_back_in_run got %b exp %b", ctl_b, C_LU); end
        cyc();
        apply_reset();
        settle();
        checks++; if (b_to !== 1'b0) begin errors++;
            $display("FAIL wd_clear got %b exp 0", b_to); end
    endtask

    task automatic test_priority();
        logic [5:0] exp_a[5] = '{C_RED, C_IMW, C_SQ, C_SQ, C_IDLE};
        apply_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        checks++; if (ctl_a !== C_RED || ctl_b !== C_RED) begin errors++;
            $display("FAIL prio got a=%b b=%b exp %b", ctl_a, ctl_b, C_RED); end
        cyc();
        for (int i = 1; i < 5; i++) begin
            set_idle();
            imem_rdy = (i != 1);
            settle();
            checks++; if (ctl_a !== exp_a[i]) begin errors++;
                $display("FAIL squash_wait_c%0d got %b exp %b", i, ctl_a, exp_a[i]); end
            cyc();
        end
        settle();
        checks++; if (a_cnt !== 8'd1) begin errors++;
            $display("FAIL squash_cnt got %0d exp 1", a_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_idle();
        mc_start = 1'b1;
        settle();
        cyc();
        set_idle();
        settle();
        checks++; if (ctl_a !== C_MC) begin errors++;
            $display("FAIL areset_pre got %b exp %b", ctl_a, C_MC); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (ctl_a !== C_IDLE || ctl_b !== C_IDLE || a_cnt !== 8'd0 || b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL areset_now got a=%b b=%b cnt=%0d/%0d exp 0", ctl_a, ctl_b, a_cnt, b_cnt); end
        cyc();
        rst_ni = 1'b1;
        model_reset();
        settle();
        checks++; if (ctl_a !== C_IDLE || a_cnt !== 8'd0) begin errors++;
            $display("FAIL areset_after got %b cnt=%0d exp 0", ctl_a, a_cnt); end
        cyc();
    endtask

    task automatic test_saturate();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            set_idle();
            imem_rdy = 1'b0;
            settle();
            if (ctl_a !== C_IMW || ctl_b !== C_IMW) bad++;
            cyc();
        end
        set_idle();
        settle();
        checks++; if (bad != 0) begin errors++;
            $display("FAIL imem_wait_ctl got %0d bad cycles exp 0", bad); end
        checks++; if (b_cnt !== 4'd15 || a_cnt !== 8'd20) begin errors++;
            $display("FAIL saturate got b=%0d a=%0d exp b=15 a=20", b_cnt, a_cnt); end
    endtask

    task automatic test_random();
        logic [5:0] ea, eb;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
            settle();
            model_eval(0, ea);
            model_eval(1, eb);
            checks++; if (ctl_a !== ea || a_to !== m_to[0] || a_cnt !== 8'(m_cnt[0])) begin errors++;
                $display("FAIL rand_a@%0d got ctl=%b to=%b cnt=%0d exp ctl=%b to=%b cnt=%0d",
                         i, ctl_a, a_to, a_cnt, ea, m_to[0], m_cnt[0]); end
            checks++; if (ctl_b !== eb || b_to !== m_to[1] || b_cnt !== 4'(m_cnt[1])) begin errors++;
                $display("FAIL rand_b@%0d got ctl=%b to=%b cnt=%0d exp ctl=%b to=%b cnt=%0d",
                         i, ctl_b, b_to, b_cnt, eb, m_to[1], m_cnt[1]); end
            cyc();
            model_commit();
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        set_idle();
        #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_mc();
        test_watchdog();
        test_priority();
        test_async_reset();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
